// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-initialisation sequencer.
package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DELAY, S_DONE, S_ERROR
  } seq_state_e;

  // Reserved device addresses: end-of-table and timed delay.
  localparam logic [6:0] DEV_END   = 7'h00;
  localparam logic [6:0] DEV_DELAY = 7'h7F;

  // Table entry layout {dev, reg, data}.
  localparam int DEV_LSB  = 16;
  localparam int REG_LSB  = 8;
  localparam int DATA_LSB = 0;

endpackage

// File: rtl/i2c_init_delay.sv
// Delay-entry tick counter: loads ticks*DELAY_UNIT, counts down, flags the last cycle.
module i2c_init_delay #(
  parameter int DELAY_UNIT = 1000,
  localparam int CNT_W = 8 + $clog2(DELAY_UNIT + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] ticks,
  output logic       expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = CNT_W'(ticks) * CNT_W'(DELAY_UNIT);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the init table and issues one 3-byte I2C write per entry to the byte master.
// Define I2C_SEQ_RETRY_EN to retry NACKed entries up to MAX_RETRY times before aborting.
module i2c_init_sequencer
  import i2c_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int DELAY_UNIT = 1000
`ifdef I2C_SEQ_RETRY_EN
  , parameter int MAX_RETRY = 3
`endif
  , localparam int IDX_W   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  output logic [IDX_W-1:0] rom_addr,
  input  logic [22:0]      rom_data,
  output logic             m_start,
  output logic [6:0]       m_dev_addr,
  output logic [7:0]       m_reg,
  output logic [7:0]       m_data,
  input  logic             m_busy,
  input  logic             m_done,
  input  logic             m_nack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index
);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d, eidx_q, eidx_d;
  logic [6:0]       dev_q, dev_d;
  logic [7:0]       reg_q, reg_d, data_q, data_d;
  logic             m_start_q, m_start_d;
  logic             advance, delay_expire;
`ifdef I2C_SEQ_RETRY_EN
  localparam int RTRY_W = $clog2(MAX_RETRY + 1);
  logic [RTRY_W-1:0] retry_q, retry_d;
`endif

  logic [6:0] ent_dev;
  logic [7:0] ent_reg, ent_data;
  assign ent_dev  = rom_data[DEV_LSB +: 7];
  assign ent_reg  = rom_data[REG_LSB +: 8];
  assign ent_data = rom_data[DATA_LSB +: 8];

  // Always loaded in DECODE; only observed while in DELAY.
  i2c_init_delay #(.DELAY_UNIT(DELAY_UNIT)) u_delay (
    .clk    (clk),
    .reset  (reset),
    .load   (state_q == S_DECODE),
    .ticks  (ent_data),
    .expire (delay_expire)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    eidx_d    = eidx_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    data_d    = data_q;
    m_start_d = 1'b0;
    advance   = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
    retry_d   = retry_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (go) begin
          state_d = S_FETCH;
          idx_d   = '0;
`ifdef I2C_SEQ_RETRY_EN
          retry_d = '0;
`endif
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (ent_dev == DEV_END) begin
          state_d = S_DONE;
        end else if (ent_dev == DEV_DELAY) begin
          if (ent_data == 8'd0) advance = 1'b1;
          else                  state_d = S_DELAY;
        end else begin
          // Fields stay put through retries of the same entry.
          dev_d   = ent_dev;
          reg_d   = ent_reg;
          data_d  = ent_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!m_busy) begin
          m_start_d = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (m_done) begin
          if (!m_nack) begin
            advance = 1'b1;
`ifdef I2C_SEQ_RETRY_EN
          end else if (retry_q < RTRY_W'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = S_ISSUE;
`endif
          end else begin
            state_d = S_ERROR;
            eidx_d  = idx_q;
          end
        end
      end
      S_DELAY: if (delay_expire) advance = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // Running off the end of the table without a marker is a clean finish.
    if (advance) begin
      if (idx_q == IDX_W'(DEPTH - 1)) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_FETCH;
      end
`ifdef I2C_SEQ_RETRY_EN
      retry_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      eidx_q    <= '0;
      dev_q     <= '0;
      reg_q     <= '0;
      data_q    <= '0;
      m_start_q <= 1'b0;
`ifdef I2C_SEQ_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      eidx_q    <= eidx_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      data_q    <= data_d;
      m_start_q <= m_start_d;
`ifdef I2C_SEQ_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign rom_addr   = idx_q;
  assign m_start    = m_start_q;
  assign m_dev_addr = dev_q;
  assign m_reg      = reg_q;
  assign m_data     = data_q;
  assign err_index  = eidx_q;
  assign busy       = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);

endmodule
